// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives the datapath control signals from state + fields.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        EQ,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_src,
   output logic        PCwrite,
   output logic        PCsrc,
   output logic [2:0]  ALUctrl,
   output logic        ALUsrc,
   output logic [2:0]  ImmSrc,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        illegal
);

   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;

   localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      I_ADD, I_SUB, I_ADDI, I_LW, I_SW, I_BEQ, I_BNE, I_LUI, I_JAL, I_BAD
   } op_t;

   state_t            state;
   state_t            next_state;
   op_t               op;
   logic [OPC_W-1:0]  opcode;
   logic [F3_W-1:0]   funct3;
   logic              funct7_5;
   logic              taken;

   // Instruction bits that carry register/immediate fields belong to the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // State register and instruction field latch (fields captured when FETCH completes).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         opcode   <= '0;
         funct3   <= '0;
         funct7_5 <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_FETCH && mem_ready) begin
            opcode   <= instr[6:0];
            funct3   <= instr[14:12];
            funct7_5 <= instr[30];
         end
      end
   end

   // Decode the latched fields into one supported operation (or illegal).
   always_comb begin
      op = I_BAD;
      case (opcode)
         OPC_RTYPE:  if (funct3 == 3'b000) op = funct7_5 ? I_SUB : I_ADD;
         OPC_ITYPE:  if (funct3 == 3'b000) op = I_ADDI;
         OPC_LOAD:   if (funct3 == 3'b010) op = I_LW;
         OPC_STORE:  if (funct3 == 3'b010) op = I_SW;
         OPC_BRANCH: begin
            if (funct3 == 3'b000)      op = I_BEQ;
            else if (funct3 == 3'b001) op = I_BNE;
         end
         OPC_LUI:    op = I_LUI;
         OPC_JAL:    op = I_JAL;
         default:    op = I_BAD;
      endcase
   end

   // Branch outcome; EQ comes straight from the combinational ALU in EXEC.
   assign taken = (op == I_BEQ) ? EQ : !EQ;

   // Next-state and control outputs, decoded from state and latched fields.
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      PCwrite    = 1'b0;
      PCsrc      = 1'b0;
      ALUctrl    = 3'b000;
      ALUsrc     = 1'b0;
      ImmSrc     = 3'b000;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      illegal    = 1'b0;
      case (state)
         S_IDLE: next_state = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               PCwrite    = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: next_state = (op == I_BAD) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            case (op)
               I_ADD: next_state = S_WB;
               I_SUB: begin
                  ALUctrl    = 3'b001;
                  next_state = S_WB;
               end
               I_ADDI: begin
                  ALUsrc     = 1'b1;
                  next_state = S_WB;
               end
               I_LW: begin
                  ALUsrc     = 1'b1;
                  next_state = S_MEMRD;
               end
               I_SW: begin
                  ALUsrc     = 1'b1;
                  ImmSrc     = 3'b001;
                  next_state = S_MEMWR;
               end
               I_BEQ, I_BNE: begin
                  ImmSrc     = 3'b010;
                  PCwrite    = taken;
                  PCsrc      = taken;
                  next_state = S_FETCH;
               end
               I_JAL: begin
                  ImmSrc     = 3'b100;
                  PCwrite    = 1'b1;
                  PCsrc      = 1'b1;
                  next_state = S_WB;
               end
               I_LUI: begin
                  ImmSrc     = 3'b011;
                  next_state = S_WB;
               end
               default: next_state = S_TRAP;
            endcase
         end
         S_MEMRD: begin
            mem_req  = 1'b1;
            addr_src = 1'b1;
            if (mem_ready) next_state = S_WB;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_src = 1'b1;
            if (mem_ready) next_state = S_FETCH;
         end
         S_WB: begin
            RegWrite   = 1'b1;
            next_state = S_FETCH;
            case (op)
               I_LW:    ResultSrc = 2'b01;
               I_JAL:   ResultSrc = 2'b10;
               I_LUI:   ResultSrc = 2'b11;
               default: ResultSrc = 2'b00;
            endcase
         end
         S_TRAP: illegal = 1'b1;
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle's expected control vector is
// queued as the stimulus is driven and compared against the DUT outputs.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        mem_ready = 1'b0;
   logic        EQ = 1'b0;
   logic        mem_req, mem_we, addr_src, PCwrite, PCsrc, ALUsrc, RegWrite, illegal;
   logic [2:0]  ALUctrl, ImmSrc;
   logic [1:0]  ResultSrc;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_src;
      logic       pcwrite;
      logic       pcsrc;
      logic [2:0] aluctrl;
      logic       alusrc;
      logic [2:0] immsrc;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic       illegal;
   } outs_t;

   outs_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .EQ(EQ),
      .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .PCwrite(PCwrite),
      .PCsrc(PCsrc), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic outs_t mk(input logic mr, input logic we, input logic as,
                                input logic pw, input logic ps, input logic [2:0] ac,
                                input logic alus, input logic [2:0] imm,
                                input logic rw, input logic [1:0] rs, input logic ill);
      outs_t o;
      o = '{mem_req: mr, mem_we: we, addr_src: as, pcwrite: pw, pcsrc: ps, aluctrl: ac,
            alusrc: alus, immsrc: imm, regwrite: rw, resultsrc: rs, illegal: ill};
      return o;
   endfunction

   // Push the expected vector, let the combinational outputs settle, pop and compare.
   task automatic chk(input string tag, input outs_t exp);
      outs_t obs;
      outs_t e;
      exp_q.push_back(exp);
      #1;
      obs = '{mem_req, mem_we, addr_src, PCwrite, PCsrc, ALUctrl, ALUsrc, ImmSrc,
              RegWrite, ResultSrc, illegal};
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, 16'(obs), 16'(e));
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, check, advance.
   task automatic step(input string tag, input logic rdy, input logic eq, input outs_t exp);
      mem_ready = rdy;
      EQ        = eq;
      chk(tag, exp);
      @(negedge clk);
   endtask

   outs_t z, f_wait, f_go, ex_br_t, ex_br_n, mrd, mwr;

   initial begin
      z       = '0;
      f_wait  = mk(1, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 2'b00, 0);
      f_go    = mk(1, 0, 0, 1, 0, 3'b000, 0, 3'b000, 0, 2'b00, 0);
      ex_br_t = mk(0, 0, 0, 1, 1, 3'b000, 0, 3'b010, 0, 2'b00, 0);
      ex_br_n = mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b010, 0, 2'b00, 0);
      mrd     = mk(1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 0, 2'b00, 0);
      mwr     = mk(1, 1, 1, 0, 0, 3'b000, 0, 3'b000, 0, 2'b00, 0);

      // Reset held for three cycles, then IDLE for one cycle (mem_ready ignored).
      @(negedge clk);
      for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b0, z);
      rst_n = 1'b1;
      step("idle", 1'b1, 1'b0, z);

      // add, zero-wait: FETCH, DECODE, EXEC, WB.
      instr = 32'h002081B3;
      step("add_fetch", 1'b1, 1'b0, f_go);
      step("add_decode", 1'b1, 1'b1, z);
      step("add_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 2'b00, 0));
      step("add_wb", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 2'b00, 0));

      // sub.
      instr = 32'h402081B3;
      step("sub_fetch", 1'b1, 1'b0, f_go);
      step("sub_decode", 1'b0, 1'b0, z);
      step("sub_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b001, 0, 3'b000, 0, 2'b00, 0));
      step("sub_wb", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 2'b00, 0));

      // lw with two MEMRD wait cycles: 7 cycles in total.
      instr = 32'h0040A183;
      step("lw_fetch", 1'b1, 1'b0, f_go);
      instr = 32'hFFFFFFFF;
      step("lw_decode", 1'b0, 1'b0, z);
      step("lw_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 1, 3'b000, 0, 2'b00, 0));
      step("lw_memrd_w0", 1'b0, 1'b0, mrd);
      step("lw_memrd_w1", 1'b0, 1'b0, mrd);
      step("lw_memrd_go", 1'b1, 1'b0, mrd);
      step("lw_wb", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 2'b01, 0));

      // addi with one FETCH wait cycle.
      instr = 32'h00408193;
      step("addi_fetch_w", 1'b0, 1'b0, f_wait);
      step("addi_fetch", 1'b1, 1'b0, f_go);
      step("addi_decode", 1'b0, 1'b0, z);
      step("addi_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 1, 3'b000, 0, 2'b00, 0));
      step("addi_wb", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 2'b00, 0));

      // beq taken / not taken; EQ outside EXEC is irrelevant.
      instr = 32'h00208463;
      step("beq_t_fetch", 1'b1, 1'b0, f_go);
      step("beq_t_decode", 1'b0, 1'b0, z);
      step("beq_t_exec", 1'b0, 1'b1, ex_br_t);
      step("beq_n_fetch", 1'b1, 1'b1, f_go);
      step("beq_n_decode", 1'b0, 1'b1, z);
      step("beq_n_exec", 1'b0, 1'b0, ex_br_n);

      // bne taken (EQ=0) and not taken (EQ=1).
      instr = 32'h00209463;
      step("bne_t_fetch", 1'b1, 1'b0, f_go);
      step("bne_t_decode", 1'b0, 1'b1, z);
      step("bne_t_exec", 1'b0, 1'b0, ex_br_t);
      step("bne_n_fetch", 1'b1, 1'b0, f_go);
      step("bne_n_decode", 1'b0, 1'b0, z);
      step("bne_n_exec", 1'b1, 1'b1, ex_br_n);

      // sw with a zero-wait store.
      instr = 32'h0020A423;
      step("sw_fetch", 1'b1, 1'b0, f_go);
      step("sw_decode", 1'b0, 1'b0, z);
      step("sw_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 1, 3'b001, 0, 2'b00, 0));
      step("sw_memwr", 1'b1, 1'b0, mwr);

      // jal.
      instr = 32'h008000EF;
      step("jal_fetch", 1'b1, 1'b0, f_go);
      step("jal_decode", 1'b0, 1'b0, z);
      step("jal_exec", 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 3'b000, 0, 3'b100, 0, 2'b00, 0));
      step("jal_wb", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 2'b10, 0));

      // lui.
      instr = 32'h123451B7;
      step("lui_fetch", 1'b1, 1'b0, f_go);
      step("lui_decode", 1'b0, 1'b0, z);
      step("lui_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b011, 0, 2'b00, 0));
      step("lui_wb", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 2'b11, 0));

      // Unknown opcode traps; illegal held with all else 0 for 20 cycles.
      instr = 32'h0000000B;
      step("ill_fetch", 1'b1, 1'b0, f_go);
      step("ill_decode", 1'b1, 1'b0, z);
      for (int i = 0; i < 20; i++)
         step("ill_trap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 2'b00, 1));
      rst_n = 1'b0;
      chk("ill_reset_clears", z);
      @(negedge clk);
      rst_n = 1'b1;
      step("ill_idle", 1'b0, 1'b0, z);

      // R-type with unsupported funct3 also traps.
      instr = 32'h002091B3;
      step("sll_fetch", 1'b1, 1'b0, f_go);
      step("sll_decode", 1'b0, 1'b0, z);
      step("sll_trap", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 2'b00, 1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step("sll_idle", 1'b0, 1'b0, z);

      // Asynchronous reset while MEMWR is waiting: request drops immediately.
      instr = 32'h0020A423;
      step("swr_fetch", 1'b1, 1'b0, f_go);
      step("swr_decode", 1'b0, 1'b0, z);
      step("swr_exec", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 3'b000, 1, 3'b001, 0, 2'b00, 0));
      step("swr_memwr_w0", 1'b0, 1'b0, mwr);
      mem_ready = 1'b0;
      chk("swr_memwr_w1", mwr);
      rst_n = 1'b0;
      chk("swr_async_drop", z);
      @(negedge clk);
      step("swr_reset_hold", 1'b0, 1'b0, z);
      rst_n = 1'b1;
      step("swr_idle", 1'b1, 1'b0, z);
      step("swr_fetch_clean_w", 1'b0, 1'b0, f_wait);
      step("swr_fetch_clean", 1'b1, 1'b0, f_go);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I single-issue core. It drives the ALU control code, consumes the ALU `EQ` flag, and sequences fetch, decode, execute, memory and writeback over several cycles. It stalls on a shared instruction/data memory with a request/ready handshake. It sits beside the datapath and is the only producer of `ALUctrl` and the only consumer of `EQ`.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  memory read data; sampled as the instruction when FETCH completes.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `EQ`  in  1  ALU equality flag (`ALUop1 == ALUop2`).
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  the access is a write.
- `addr_src`  out  1  0 = PC, 1 = ALU result.
- `PCwrite`  out  1  PC register load enable.
- `PCsrc`  out  1  0 = PC+4, 1 = PC+imm.
- `ALUctrl`  out  3  000 = ADD, 001 = SUB; other codes are never driven.
- `ALUsrc`  out  1  0 = rs2, 1 = immediate.
- `ImmSrc`  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  00 = ALU, 01 = memory data, 10 = PC+4, 11 = immediate.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, TRAP.
- All outputs are combinational from the state and the latched fields (`opcode`, `funct3`, `funct7[5]`).
- In IDLE every output is 0.
- IDLE goes to FETCH unconditionally.
- FETCH:
  - Drives `mem_req=1`, `addr_src=0`, `mem_we=0`.
  - Holds while `mem_ready=0`.
  - On `mem_ready=1`: latch the fields from `instr`, pulse `PCwrite=1` with `PCsrc=0`, go to DECODE.
- DECODE: all outputs 0. The next state follows the latched opcode:
  - 0110011 (R-type) goes to EXEC only for `funct3=000` (`funct7[5]`: 0 = add, 1 = sub).
  - 0010011 (I-type) goes to EXEC only for `funct3=000` (addi).
  - 0000011 goes to EXEC for `funct3=010` (lw). 0100011 goes to EXEC for `funct3=010` (sw).
  - 1100011 goes to EXEC for `funct3` 000 (beq) or 001 (bne).
  - 0110111 (lui) and 1101111 (jal) go to EXEC.
  - Anything else goes to TRAP.
- EXEC, per instruction:
  - add/sub: `ALUsrc=0`, `ALUctrl`=000 or 001, then WB.
  - addi: `ALUsrc=1`, `ImmSrc=000`, `ALUctrl=000`, then WB.
  - lw: `ALUsrc=1`, `ImmSrc=000`, `ALUctrl=000`, then MEMRD.
  - sw: `ALUsrc=1`, `ImmSrc=001`, `ALUctrl=000`, then MEMWR.
  - beq/bne: `ALUsrc=0`, `ImmSrc=010`. Taken = `EQ` for beq, `!EQ` for bne. If taken, `PCwrite=1` and `PCsrc=1`. Then FETCH.
  - jal: `ImmSrc=100`, `PCwrite=1`, `PCsrc=1`, then WB.
  - lui: `ImmSrc=011`, then WB.
- MEMRD: `mem_req=1`, `addr_src=1`. Holds until `mem_ready`, then WB.
- MEMWR: `mem_req=1`, `mem_we=1`, `addr_src=1`. Holds until `mem_ready`, then FETCH.
- WB: `RegWrite=1`, then FETCH. `ResultSrc` per instruction:
  - 00 for add/sub/addi.
  - 01 for lw.
  - 10 for jal.
  - 11 for lui.
- TRAP:
  - `illegal=1`; every other output is 0.
  - Stays in TRAP until reset.
- Datapath contract: PC+imm uses the old PC, which the datapath holds in OldPC captured at FETCH.

## Timing
- Reset: asserting `rst_n` low forces IDLE immediately, asynchronously, even mid-access. An outstanding request is abandoned (`mem_req` drops the same instant).
- The first FETCH is one cycle after `rst_n` deasserts.
- Latency with zero-wait memory (`mem_ready` high in the request cycle), counted FETCH to the next FETCH:
  - beq/bne: 3 cycles.
  - add/sub/addi/lui/sw/jal: 4 cycles.
  - lw: 5 cycles.
- Every memory wait cycle adds exactly one cycle.
- `mem_ready` outside FETCH/MEMRD/MEMWR is ignored.
- `EQ` is sampled only in EXEC for a branch. It must be valid in that same cycle (the ALU is combinational).
- `PCwrite` is a single-cycle pulse.
- FETCH with `mem_ready` held low forever: no outputs change and there is no timeout.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles -> every output is 0. Release -> IDLE for 1 cycle, then FETCH with `mem_req=1`, `addr_src=0`.
- add then sub, zero-wait:
  - `instr=0x002081B3` -> `ALUctrl=000` in EXEC, `RegWrite=1`, `ResultSrc=00` in WB, 4 cycles total.
  - `instr=0x402081B3` -> `ALUctrl=001`.
- lw with 2 wait cycles in MEMRD: `instr=0x0040A183` -> `mem_req=1`, `addr_src=1` for 3 cycles, then WB with `ResultSrc=01`, 7 cycles total.
- Branches, `instr=0x00208463` (beq):
  - `EQ=1` -> `PCwrite=1`, `PCsrc=1` in EXEC.
  - `EQ=0` -> `PCwrite=0`.
  - bne (`0x00209463`) with `EQ=0` -> taken.
- Illegal: `instr=0x0000000B` -> DECODE goes to TRAP, `illegal=1` held for 20 cycles with every other output 0. Reset clears it.
- Reset during MEMWR while `mem_ready=0` -> `mem_req` and `mem_we` drop asynchronously. After release, a clean FETCH.
